// File: rtl/jps_pkg.sv
// Shared types and Johnson-code helpers for the phase sequencer.
// Helpers work on a fixed-width word so one package serves any stage count.
package jps_pkg;

   localparam int JPS_MAX_N = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef logic [JPS_MAX_N-1:0] jc_word_t;

   function automatic jc_word_t jc_mask(input int n);
      return (jc_word_t'(1) << n) - jc_word_t'(1);
   endfunction

   // Code shown at phase p: p low ones on the way up, then ones drain from the LSB.
   function automatic jc_word_t jc_code(input int p, input int n);
      jc_word_t c;
      if (p < n) c = (jc_word_t'(1) << p) - jc_word_t'(1);
      else       c = jc_mask(n) & ~((jc_word_t'(1) << (p - n)) - jc_word_t'(1));
      return c;
   endfunction

   function automatic logic jc_legal(input jc_word_t c, input int n);
      logic ok;
      ok = 1'b0;
      for (int p = 0; p < 2*JPS_MAX_N; p++) begin
         if (p < 2*n && c == jc_code(p, n)) ok = 1'b1;
      end
      return ok;
   endfunction

   function automatic int jc_phase(input jc_word_t c, input int n);
      int ph;
      ph = 0;
      for (int p = 0; p < 2*JPS_MAX_N; p++) begin
         if (p < 2*n && c == jc_code(p, n)) ph = p;
      end
      return ph;
   endfunction

   function automatic jc_word_t jc_next(input jc_word_t c, input int n);
      jc_word_t msb;
      msb = (c >> (n - 1)) & jc_word_t'(1);
      return ((c << 1) & jc_mask(n)) | (msb ^ jc_word_t'(1));
   endfunction

endpackage

// File: rtl/johnson_core.sv
// N-stage Johnson register; clear wins over enable.
module johnson_core
   import jps_pkg::*;
#(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [N-1:0] q
);

   logic [N-1:0] q_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_r <= '0;
      end else if (clr) begin
         q_r <= '0;
      end else if (en) begin
         q_r <= N'(jc_next(jc_word_t'(q_r), N));
      end
   end

   assign q = q_r;

endmodule

// File: rtl/johnson_phase_sequencer.sv
// Runs a Johnson counter for a programmed number of full cycles with hold,
// abort and recovery from illegal codes.
//
//   state   | meaning
//   IDLE    | counter cleared, waiting for start
//   RUN     | counter stepping (busy), counting completed cycles
//   DONE    | one-cycle done pulse, then back to IDLE
module johnson_phase_sequencer
   import jps_pkg::*;
#(
   parameter int N  = 3,
   parameter int CW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [CW-1:0]   num_cycles,
   input  logic            hold,
   input  logic            abort,
   output logic [N-1:0]    jc_q,
   output logic [2*N-1:0]  phase_oh,
   output logic [CW-1:0]   cycle_cnt,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int PW = 2*N;

   state_t        state, state_nxt;
   logic [CW-1:0] target, target_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          err_r, err_nxt;
   logic          core_en, core_clr;
   logic          legal, last_ph;
   int            ph_idx;

   johnson_core #(.N(N)) u_core (
      .clk   (clk),
      .reset (reset),
      .en    (core_en),
      .clr   (core_clr),
      .q     (jc_q)
   );

   assign legal   = jc_legal(jc_word_t'(jc_q), N);
   assign ph_idx  = jc_phase(jc_word_t'(jc_q), N);
   assign last_ph = legal && (ph_idx == PW - 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         target <= '0;
         cnt    <= '0;
         err_r  <= 1'b0;
      end else begin
         state  <= state_nxt;
         target <= target_nxt;
         cnt    <= cnt_nxt;
         err_r  <= err_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      target_nxt = target;
      cnt_nxt    = cnt;
      err_nxt    = 1'b0;
      core_en    = 1'b0;
      core_clr   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            core_clr = 1'b1;
            if (start) begin
               if (num_cycles != '0) begin
                  target_nxt = num_cycles;
                  cnt_nxt    = '0;
                  state_nxt  = ST_RUN;
               end else begin
                  state_nxt  = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               core_clr  = 1'b1;
               state_nxt = ST_IDLE;
            end else if (!legal) begin
               core_clr = 1'b1;
               err_nxt  = 1'b1;
            end else if (!hold) begin
               // stepping from the last phase lands on zero, which is the wrap
               core_en = 1'b1;
               if (last_ph) begin
                  cnt_nxt = cnt + 1'b1;
                  if (cnt_nxt == target) state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            core_clr  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            core_clr  = 1'b1;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy      = (state == ST_RUN);
   assign done      = (state == ST_DONE);
   assign err       = err_r;
   assign cycle_cnt = cnt;
   assign phase_oh  = (busy && legal) ? (PW'(1) << ph_idx) : '0;

endmodule

// File: doc/johnson_phase_sequencer.md
Name: johnson_phase_sequencer

Overview:
- Controller that runs an N-stage Johnson counter for a programmed number of full Johnson cycles (2N phases each) after a start request.
- Outputs a one-hot phase enable, busy/done status and a fault flag.
- Sits between a host or control FSM and multi-phase datapath logic such as clock-phase enables or stepper drives.
- Supports hold (pause), abort, and self-recovery from illegal counter codes.

Parameters:
N, 3, number of Johnson stages; 2N phases per cycle; N >= 2
CW, 8, width of the cycle-count target and of the completed-cycle counter

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a run; sampled only in IDLE
num_cycles  input  CW  number of full Johnson cycles to run; sampled together with start
hold  input  1  freeze counter and cycle count while in RUN
abort  input  1  terminate a run immediately, without done
jc_q  output  N  raw Johnson counter state, {qN-1..q0}
phase_oh  output  2N  one-hot current phase while busy; all zero when not busy
cycle_cnt  output  CW  full cycles completed in the current run
busy  output  1  high in RUN state
done  output  1  one-cycle pulse when a run completes normally
err  output  1  one-cycle pulse when an illegal jc_q code was corrected

Behaviour:
- Reset (asynchronous): state IDLE, jc_q=0, cycle_cnt=0, target=0, busy=0, done=0, err=0, phase_oh=0.
- Johnson step: jc_q <= {jc_q[N-2:0], ~jc_q[N-1]}.
  - N=3 sequence: 000, 001, 011, 111, 110, 100, then 000.
  - Phase index p = position of jc_q in this sequence.
  - phase_oh = 1<<p when busy.
- States are IDLE, RUN and DONE; busy = (state==RUN).
- IDLE:
  - jc_q is held at 0.
  - start=1 with num_cycles != 0: latch target=num_cycles, clear cycle_cnt, go to RUN. First busy cycle shows phase 0 (jc_q=0).
  - start=1 with num_cycles == 0: go to DONE; busy never asserts.
  - abort and hold are ignored.
- RUN, priority abort > illegal code > hold > advance:
  - abort=1: next state IDLE, jc_q=0, cycle_cnt is kept for observation, no done.
  - jc_q not a legal Johnson code: next jc_q=0, err=1 for one cycle, cycle_cnt unchanged, stay in RUN.
  - hold=1: jc_q and cycle_cnt are frozen; busy stays 1.
  - Otherwise jc_q advances one step per clock.
  - Wrap from the last phase (only MSB set) to 000: cycle_cnt increments. If cycle_cnt+1 == target, go to DONE (jc_q=0).
- DONE: done=1, busy=0, phase_oh=0 for exactly one cycle, then IDLE. start sampled in DONE is ignored.
- start while in RUN is ignored; num_cycles changes during a run have no effect.
- Latency: start sampled at edge k gives busy=1 from edge k+1. With no hold, busy lasts exactly 2N*num_cycles cycles and done is high in the next cycle. Each held cycle extends the run by one.
- cycle_cnt cannot overflow because target <= 2^CW-1.
- Reset asserted mid-run: all outputs return to reset values immediately, without waiting for a clock edge. No done is issued.

Decomposition:
- Package jps_pkg:
  - state enum (IDLE, RUN, DONE)
  - function jc_legal(N-bit) -> bit
  - function jc_phase(N-bit) -> index
  - function jc_next(N-bit) -> N-bit
- One sub-module, johnson_core: N-stage Johnson register with clk, reset, en, clr inputs, q output.
  - clr has priority over en.
  - The sequencer drives en and clr and decodes phase/wrap from q.

Test Plan:
- Basic run (N=3): start=1, num_cycles=2 → busy high 12 cycles. jc_q walks 000,001,011,111,110,100 twice. phase_oh walks 000001..100000. cycle_cnt goes 0→1. done=1 on cycle 13 with busy=0.
- Zero-length run: start=1, num_cycles=0 → done pulse the next cycle; busy, phase_oh and jc_q stay 0.
- Hold: num_cycles=1, hold=1 for 3 cycles while jc_q=011 → jc_q stays 011 and busy stays 1 during hold. Total busy is 9 cycles, then done.
- Abort: num_cycles=5, abort=1 at phase 4 of cycle 2 → next cycle state IDLE, jc_q=000, busy=0. done is never asserted, and cycle_cnt reads 1.
- Illegal-code recovery: during RUN, force jc_q=010 for one edge → next cycle jc_q=000 and err=1 for one cycle. Run continues with cycle_cnt unchanged.
- Async reset mid-run: assert reset between clock edges at phase 3 → busy, done, phase_oh and jc_q go to 0 immediately. After release, a new start runs normally.
